// File: rtl/layer_serializer_pkg.sv
// layer_serializer_pkg: shared network constants and serializer state encoding
package layer_serializer_pkg;
   localparam int NUM_LAYERS       = 3;
   localparam int INPUT_NEURONS    = 30;
   localparam int HIDDEN_NEURONS   = 30;
   localparam int OUTPUT_NEURONS   = 10;
   localparam int DEF_NUM_NEURONS  = 30;
   localparam int DEF_DATA_WIDTH   = 16;
   typedef enum logic {IDLE, STREAM} ser_state_t;
endpackage

// File: rtl/layer_serializer.sv
// layer_serializer: captures a layer's parallel neuron outputs and streams them one word per cycle
module layer_serializer
   import layer_serializer_pkg::*;
#(
   parameter int NUM_NEURONS = DEF_NUM_NEURONS,
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_NEURONS-1:0]            x_valid,
   input  logic [NUM_NEURONS*DATA_WIDTH-1:0] x_in,
   output logic [DATA_WIDTH-1:0]             data_out,
   output logic                              data_out_valid,
   output logic                              busy,
   output logic                              done,
   output logic                              overflow
);
   localparam int IW = $clog2(NUM_NEURONS) + 1;
   localparam logic [IW-1:0] LAST = IW'(NUM_NEURONS - 1);
   ser_state_t                        r_state, w_next;
   logic [IW-1:0]                     r_idx;
   logic [NUM_NEURONS*DATA_WIDTH-1:0] r_hold;
   logic [DATA_WIDTH-1:0]             r_last, w_word;
   logic                              w_last, w_unused;
   // layer neurons share timing, so only bit 0 is a trigger
   assign w_unused       = &x_valid;
   assign w_word         = r_hold[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH];
   assign busy           = (r_state == STREAM);
   assign w_last         = busy && (r_idx == LAST);
   assign done           = w_last;
   assign data_out_valid = busy;
   assign data_out       = busy ? w_word : r_last;
   always_comb begin
      w_next = busy ? (w_last ? IDLE : STREAM) : (x_valid[0] ? STREAM : IDLE);
   end
   always_ff @(posedge clk) begin
      r_state <= rst ? IDLE : w_next;
   end
   always_ff @(posedge clk) begin
      if (!rst && !busy && x_valid[0]) r_hold <= x_in;
      if (rst) begin
         r_idx    <= '0;
         r_last   <= '0;
         overflow <= 1'b0;
      end else if (busy) begin
         r_idx  <= w_last ? '0 : r_idx + 1'b1;
         r_last <= w_word;
         if (x_valid[0]) overflow <= 1'b1;
      end else if (x_valid[0]) begin
         r_idx <= '0;
      end
   end
endmodule

// File: tb/tb_layer_serializer.sv
// tb_layer_serializer: directed and randomized checks of layer_serializer against a word-queue model
module tb_layer_serializer;
   localparam int DW = 16;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   logic [3:0]      a_xv = '0;
   logic [4*DW-1:0] a_xin = '0;
   logic [DW-1:0]   a_do;
   logic            a_v, a_busy, a_done, a_ovf;
   logic [0:0]      b_xv = '0;
   logic [DW-1:0]   b_xin = '0;
   logic [DW-1:0]   b_do;
   logic            b_v, b_busy, b_done, b_ovf;
   int checks = 0;
   int errors = 0;
   layer_serializer #(.NUM_NEURONS(4), .DATA_WIDTH(DW)) u_a (
      .clk(clk), .rst(rst), .x_valid(a_xv), .x_in(a_xin), .data_out(a_do),
      .data_out_valid(a_v), .busy(a_busy), .done(a_done), .overflow(a_ovf));
   layer_serializer #(.NUM_NEURONS(1), .DATA_WIDTH(DW)) u_b (
      .clk(clk), .rst(rst), .x_valid(b_xv), .x_in(b_xin), .data_out(b_do),
      .data_out_valid(b_v), .busy(b_busy), .done(b_done), .overflow(b_ovf));
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset;
      rst = 1'b1; a_xv = 4'hF; b_xv = 1'b1; a_xin = {$urandom, $urandom}; b_xin = DW'($urandom);
      tick;
      tick;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if ({a_v, a_busy, a_done, a_ovf} !== 4'b0000 || a_do !== '0) begin
            errors++; $display("FAIL reset_a step%0d: v/busy/done/ovf=%b data=%h, expected 0000 data=0000", k, {a_v, a_busy, a_done, a_ovf}, a_do);
         end
         checks++;
         if ({b_v, b_busy, b_done, b_ovf} !== 4'b0000 || b_do !== '0) begin
            errors++; $display("FAIL reset_b step%0d: v/busy/done/ovf=%b data=%h, expected 0000 data=0000", k, {b_v, b_busy, b_done, b_ovf}, b_do);
         end
         rst = 1'b0; a_xv = '0; b_xv = '0;
         tick;
      end
   endtask
   task automatic test_basic;
      logic [DW-1:0] w [4];
      logic [3:0] ef;
      for (int i = 0; i < 4; i++) begin w[i] = DW'(i + 1); a_xin[i*DW +: DW] = w[i]; end
      a_xv = 4'hF;
      tick;
      a_xv = '0;
      for (int k = 1; k <= 4; k++) begin
         ef = {2'b11, k == 4, 1'b0};
         checks++;
         if ({a_v, a_busy, a_done, a_ovf} !== ef || a_do !== w[k-1]) begin
            errors++; $display("FAIL basic +%0d: flags=%b data=%h, expected flags=%b data=%h", k, {a_v, a_busy, a_done, a_ovf}, a_do, ef, w[k-1]);
         end
         tick;
      end
      checks++;
      if ({a_v, a_busy, a_done, a_ovf} !== 4'b0000 || a_do !== w[3]) begin
         errors++; $display("FAIL basic_idle: flags=%b data=%h, expected flags=0000 data=%h", {a_v, a_busy, a_done, a_ovf}, a_do, w[3]);
      end
   endtask
   task automatic test_overflow;
      logic [DW-1:0] w [4];
      logic [3:0] ef;
      for (int i = 0; i < 4; i++) begin w[i] = DW'($urandom); a_xin[i*DW +: DW] = w[i]; end
      a_xv = 4'hF;
      tick;
      a_xv = '0;
      for (int k = 1; k <= 4; k++) begin
         ef = {2'b11, k == 4, k >= 3};
         checks++;
         if ({a_v, a_busy, a_done, a_ovf} !== ef || a_do !== w[k-1]) begin
            errors++; $display("FAIL overflow +%0d: flags=%b data=%h, expected flags=%b data=%h", k, {a_v, a_busy, a_done, a_ovf}, a_do, ef, w[k-1]);
         end
         a_xv = (k == 2) ? 4'hF : 4'h0;
         a_xin = {$urandom, $urandom};
         tick;
      end
      for (int k = 5; k <= 7; k++) begin
         checks++;
         if ({a_v, a_busy, a_done, a_ovf} !== 4'b0001) begin
            errors++; $display("FAIL overflow_sticky +%0d: flags=%b, expected 0001", k, {a_v, a_busy, a_done, a_ovf});
         end
         tick;
      end
   endtask
   task automatic test_reset_mid;
      logic [DW-1:0] w [4];
      logic [3:0] ef;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin w[i] = DW'($urandom); a_xin[i*DW +: DW] = w[i]; end
      a_xv = 4'hF;
      tick;
      a_xv = '0;
      for (int k = 1; k <= 2; k++) begin
         checks++;
         if ({a_v, a_busy, a_done, a_ovf} !== 4'b1100 || a_do !== w[k-1]) begin
            errors++; $display("FAIL rstmid +%0d: flags=%b data=%h, expected flags=1100 data=%h", k, {a_v, a_busy, a_done, a_ovf}, a_do, w[k-1]);
         end
         if (k == 2) rst = 1'b1;
         tick;
      end
      rst = 1'b0;
      for (int k = 3; k <= 6; k++) begin
         checks++;
         if ({a_v, a_busy, a_done, a_ovf} !== 4'b0000 || a_do !== '0) begin
            errors++; $display("FAIL rstmid_after +%0d: flags=%b data=%h, expected flags=0000 data=0000", k, {a_v, a_busy, a_done, a_ovf}, a_do);
         end
         tick;
      end
      for (int i = 0; i < 4; i++) begin w[i] = DW'($urandom); a_xin[i*DW +: DW] = w[i]; end
      a_xv = 4'hF;
      tick;
      a_xv = '0;
      for (int k = 1; k <= 4; k++) begin
         ef = {2'b11, k == 4, 1'b0};
         checks++;
         if ({a_v, a_busy, a_done, a_ovf} !== ef || a_do !== w[k-1]) begin
            errors++; $display("FAIL rstmid_new +%0d: flags=%b data=%h, expected flags=%b data=%h", k, {a_v, a_busy, a_done, a_ovf}, a_do, ef, w[k-1]);
         end
         tick;
      end
   endtask
   task automatic test_back_to_back;
      logic [DW-1:0] w [8];
      logic [3:0] ef;
      for (int i = 0; i < 4; i++) begin w[i] = DW'($urandom); w[i+4] = DW'(16'hA + i); a_xin[i*DW +: DW] = w[i]; end
      a_xv = 4'hF;
      tick;
      a_xv = '0;
      for (int k = 1; k <= 9; k++) begin
         ef = (k == 5) ? 4'b0000 : {2'b11, k == 4 || k == 9, 1'b0};
         checks++;
         if ({a_v, a_busy, a_done, a_ovf} !== ef || (k != 5 && a_do !== w[k > 5 ? k-2 : k-1])) begin
            errors++; $display("FAIL b2b +%0d: flags=%b data=%h, expected flags=%b data=%h", k, {a_v, a_busy, a_done, a_ovf}, a_do, ef, w[k > 5 ? k-2 : k-1]);
         end
         if (k == 5) for (int i = 0; i < 4; i++) a_xin[i*DW +: DW] = w[i+4];
         a_xv = (k == 5) ? 4'hF : 4'h0;
         tick;
      end
      checks++;
      if ({a_v, a_busy, a_done, a_ovf} !== 4'b0000) begin
         errors++; $display("FAIL b2b_idle: flags=%b, expected 0000", {a_v, a_busy, a_done, a_ovf});
      end
   endtask
   task automatic test_done_overflow;
      a_xin = {$urandom, $urandom};
      a_xv = 4'hF;
      tick;
      a_xv = '0;
      tick; tick; tick;
      checks++;
      if ({a_v, a_busy, a_done, a_ovf} !== 4'b1110) begin
         errors++; $display("FAIL doneovf_last: flags=%b, expected 1110", {a_v, a_busy, a_done, a_ovf});
      end
      a_xv = 4'hF;
      tick;
      a_xv = '0;
      for (int k = 5; k <= 6; k++) begin
         checks++;
         if ({a_v, a_busy, a_done, a_ovf} !== 4'b0001) begin
            errors++; $display("FAIL doneovf +%0d: flags=%b, expected 0001", k, {a_v, a_busy, a_done, a_ovf});
         end
         tick;
      end
   endtask
   task automatic test_single;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      b_xin = 16'h8000; b_xv = 1'b1;
      tick;
      b_xv = 1'b0;
      checks++;
      if ({b_v, b_busy, b_done, b_ovf} !== 4'b1110 || b_do !== 16'h8000) begin
         errors++; $display("FAIL single +1: flags=%b data=%h, expected flags=1110 data=8000", {b_v, b_busy, b_done, b_ovf}, b_do);
      end
      tick;
      checks++;
      if ({b_v, b_busy, b_done, b_ovf} !== 4'b0000 || b_do !== 16'h8000) begin
         errors++; $display("FAIL single +2: flags=%b data=%h, expected flags=0000 data=8000", {b_v, b_busy, b_done, b_ovf}, b_do);
      end
      b_xin = 16'h1234; b_xv = 1'b1;
      tick;
      checks++;
      if ({b_v, b_busy, b_done, b_ovf} !== 4'b1110 || b_do !== 16'h1234) begin
         errors++; $display("FAIL single_b2b: flags=%b data=%h, expected flags=1110 data=1234", {b_v, b_busy, b_done, b_ovf}, b_do);
      end
      b_xin = 16'h5555;
      tick;
      b_xv = 1'b0;
      checks++;
      if ({b_v, b_busy, b_done, b_ovf} !== 4'b0001 || b_do !== 16'h1234) begin
         errors++; $display("FAIL single_ovf: flags=%b data=%h, expected flags=0001 data=1234", {b_v, b_busy, b_done, b_ovf}, b_do);
      end
   endtask
   task automatic test_random;
      logic [DW-1:0] q [$];
      logic [DW-1:0] e;
      logic [3:0] ef;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      for (int b = 0; b < 1000; b++) begin
         for (int g = $urandom_range(3); g > 0; g--) begin
            a_xv = 4'($urandom) & 4'hE;
            a_xin = {$urandom, $urandom};
            tick;
            checks++;
            if ({a_v, a_busy, a_done, a_ovf} !== 4'b0000) begin
               errors++; $display("FAIL random_idle burst%0d: flags=%b, expected 0000", b, {a_v, a_busy, a_done, a_ovf});
            end
         end
         a_xin = {$urandom, $urandom};
         for (int i = 0; i < 4; i++) q.push_back(a_xin[i*DW +: DW]);
         a_xv = 4'($urandom) | 4'h1;
         tick;
         while (q.size() > 0) begin
            e = q.pop_front();
            ef = {2'b11, q.size() == 0, 1'b0};
            checks++;
            if ({a_v, a_busy, a_done, a_ovf} !== ef || a_do !== e) begin
               errors++; $display("FAIL random burst%0d: flags=%b data=%h, expected flags=%b data=%h", b, {a_v, a_busy, a_done, a_ovf}, a_do, ef, e);
            end
            a_xv = 4'($urandom) & 4'hE;
            a_xin = {$urandom, $urandom};
            tick;
         end
      end
      checks++;
      if (a_ovf !== 1'b0) begin
         errors++; $display("FAIL random_ovf: overflow=%b, expected 0", a_ovf);
      end
   endtask
   initial begin
      test_reset;
      test_basic;
      test_overflow;
      test_reset_mid;
      test_back_to_back;
      test_done_overflow;
      test_single;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
